irq_source_ctrl: RTL and testbench

Peripheral-side interrupt requester that drives the CPU's two-line interrupt interface (IRQ_RAISE[1:0] / IRQ_ACK[1:0]). It turns one-cycle event strobes, plus an optional internal periodic timer on channel 0, into level interrupt requests. Each request is held until the CPU acknowledges it. Each channel queues one further event while busy and counts any events lost beyond that. It sits between the peripherals and the CPU top level, in place of the bench-driven IRQ_RAISE stimulus.

---
 rtl/irq_source_ctrl.sv | 158 +++++++++++++++
 tb/tb_irq_source_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// Two-channel interrupt requester: event strobes (plus an optional periodic tick on
// channel 0) become level requests held until the CPU acks, with one-deep queueing.
module irq_source_ctrl #(
  parameter int unsigned TIMER_PERIOD = 0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       EVENT_IN,
  input  logic [1:0]       IRQ_ACK,
  input  logic [1:0]       OVF_CLR,
  output logic [1:0]       IRQ_RAISE,
  output logic [CNT_W-1:0] OVF_COUNT0,
  output logic [CNT_W-1:0] OVF_COUNT1
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAISED = 2'd1,
    ST_ACKED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                  tick_s;
  logic [1:0]            event_s;
  logic [1:0]            ovf_inc_s;
  state_t [1:0]          state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0][CNT_W-1:0] ovf_q, ovf_d;

  generate
    if (TIMER_PERIOD > 0) begin : g_timer
      localparam int unsigned      TW       = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
      localparam logic [TW-1:0]    TMR_LAST = TW'(TIMER_PERIOD - 1);
      logic [TW-1:0] tmr_q, tmr_d;

      always_comb begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          tmr_q <= '0;
        end else begin
          tmr_q <= tmr_d;
        end
      end

      assign tick_s = (tmr_q == TMR_LAST);
    end else begin : g_no_timer
      assign tick_s = 1'b0;
    end
  endgenerate

  // A tick coinciding with a channel-0 strobe is deliberately a single event.
  assign event_s = EVENT_IN | {1'b0, tick_s};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
      end
      pend_q <= 2'b00;
      ovf_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ovf_inc_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (event_s[i]) begin
            state_d[i] = ST_RAISED;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_RAISED: begin
          if (IRQ_ACK[i]) begin
            state_d[i] = ST_ACKED;
          end else begin
            state_d[i] = ST_RAISED;
          end
          if (event_s[i]) begin
            if (pend_q[i]) begin
              ovf_inc_s[i] = 1'b1;
            end else begin
              pend_d[i] = 1'b1;
            end
          end else begin
            pend_d[i] = pend_q[i];
          end
        end
        ST_ACKED: begin
          if (IRQ_ACK[i]) begin
            state_d[i] = ST_ACKED;
            if (event_s[i] && pend_q[i]) begin
              ovf_inc_s[i] = 1'b1;
            end else if (event_s[i]) begin
              pend_d[i] = 1'b1;
            end else begin
              pend_d[i] = pend_q[i];
            end
          end else if (pend_q[i]) begin
            // Queued event is consumed by the re-raise; a same-cycle event refills the slot.
            state_d[i] = ST_RAISED;
            pend_d[i]  = event_s[i];
          end else if (event_s[i]) begin
            state_d[i] = ST_RAISED;
            pend_d[i]  = 1'b0;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          pend_d[i]  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < 2; i++) begin
      if (OVF_CLR[i]) begin
        ovf_d[i] = ovf_inc_s[i] ? CNT_W'(1) : '0;
      end else if (ovf_inc_s[i] && (ovf_q[i] != CNT_MAX)) begin
        ovf_d[i] = ovf_q[i] + CNT_W'(1);
      end else begin
        ovf_d[i] = ovf_q[i];
      end
    end
  end

  always_comb begin
    IRQ_RAISE = 2'b00;
    for (int i = 0; i < 2; i++) begin
      IRQ_RAISE[i] = (state_q[i] == ST_RAISED);
    end
  end

  assign OVF_COUNT0 = ovf_q[0];
  assign OVF_COUNT1 = ovf_q[1];

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed self-checking bench: one instance without timer, one with a 10-cycle timer.
module tb_irq_source_ctrl;

  logic       clk;
  logic       rst, rst_t;
  logic [1:0] ev, ack, clr;
  logic [1:0] ev_t, ack_t, clr_t;
  logic [1:0] raise, raise_t;
  logic [7:0] ovf0, ovf1, ovf0_t, ovf1_t;
  int         n_assert;
  int         n_fail;

  irq_source_ctrl #(.TIMER_PERIOD(0), .CNT_W(8)) dut (
    .CLK(clk), .RESET(rst), .EVENT_IN(ev), .IRQ_ACK(ack), .OVF_CLR(clr),
    .IRQ_RAISE(raise), .OVF_COUNT0(ovf0), .OVF_COUNT1(ovf1)
  );

  irq_source_ctrl #(.TIMER_PERIOD(10), .CNT_W(8)) dut_t (
    .CLK(clk), .RESET(rst_t), .EVENT_IN(ev_t), .IRQ_ACK(ack_t), .OVF_CLR(clr_t),
    .IRQ_RAISE(raise_t), .OVF_COUNT0(ovf0_t), .OVF_COUNT1(ovf1_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; rst_t = 1'b1;
    ev = 2'b00; ack = 2'b00; clr = 2'b00;
    ev_t = 2'b00; ack_t = 2'b00; clr_t = 2'b00;

    // Reset
    step(3);
    check("rst_raise", 32'(raise), 32'd0);
    check("rst_ovf0", 32'(ovf0), 32'd0);
    check("rst_ovf1", 32'(ovf1), 32'd0);
    rst = 1'b0;
    step(1);

    // Basic handshake
    ev = 2'b01; step(1); ev = 2'b00;
    check("hs_raise", 32'(raise), 32'd1);
    step(4);
    check("hs_hold", 32'(raise), 32'd1);
    ack = 2'b01; step(1); ack = 2'b00;
    check("hs_drop", 32'(raise), 32'd0);
    check("hs_ovf0", 32'(ovf0), 32'd0);
    step(1);
    check("hs_idle", 32'(raise), 32'd0);

    // Level ack with queued event on channel 1
    ev = 2'b10; step(1); ev = 2'b00;
    check("lv_raise", 32'(raise), 32'd2);
    ev = 2'b10; step(1); ev = 2'b00;
    check("lv_pend_raise", 32'(raise), 32'd2);
    ack = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("lv_ack_low", 32'(raise), 32'd0);
    end
    ack = 2'b00; step(1);
    check("lv_reraise", 32'(raise), 32'd2);
    check("lv_ovf1", 32'(ovf1), 32'd0);
    ack = 2'b10; step(1); ack = 2'b00; step(1);
    check("lv_idle", 32'(raise), 32'd0);

    // Overflow and saturation on channel 0
    ev = 2'b01; step(1);
    check("ov_raise", 32'(raise), 32'd1);
    step(1);
    check("ov_pend_only", 32'(ovf0), 32'd0);
    step(1);
    check("ov_first_loss", 32'(ovf0), 32'd1);
    step(298); ev = 2'b00;
    check("ov_saturate", 32'(ovf0), 32'd255);
    clr = 2'b01; ev = 2'b01; step(1); clr = 2'b00; ev = 2'b00;
    check("ov_clr_inc", 32'(ovf0), 32'd1);
    clr = 2'b01; step(1); clr = 2'b00;
    check("ov_clr", 32'(ovf0), 32'd0);
    ack = 2'b01; step(1); ack = 2'b00;
    check("ov_ack_drop", 32'(raise), 32'd0);
    step(1);
    check("ov_pend_reraise", 32'(raise), 32'd1);
    ack = 2'b01; step(1); ack = 2'b00; step(1);
    check("ov_idle", 32'(raise), 32'd0);

    // Simultaneous channels, then reset mid-handshake
    ev = 2'b11; step(1); ev = 2'b00;
    check("sim_both", 32'(raise), 32'd3);
    ack = 2'b10; step(1); ack = 2'b00;
    check("sim_ch1_drop", 32'(raise), 32'd1);
    ev = 2'b01; step(1);
    step(1); ev = 2'b00;
    check("sim_ovf0", 32'(ovf0), 32'd1);
    rst = 1'b1; step(1);
    check("sim_rst_raise", 32'(raise), 32'd0);
    check("sim_rst_ovf0", 32'(ovf0), 32'd0);
    check("sim_rst_ovf1", 32'(ovf1), 32'd0);
    rst = 1'b0; step(3);
    check("sim_no_reraise", 32'(raise), 32'd0);

    // Spurious ack, then event while ack is still high
    ack = 2'b11; step(2);
    check("sp_no_change", 32'(raise), 32'd0);
    ev = 2'b01; step(1); ev = 2'b00;
    check("sp_raise", 32'(raise), 32'd1);
    step(1);
    check("sp_drop", 32'(raise), 32'd0);
    ack = 2'b00; step(1);
    check("sp_idle", 32'(raise), 32'd0);
    check("sp_ovf0", 32'(ovf0), 32'd0);

    // Timer instance: ticks every 10 cycles after reset release
    rst_t = 1'b0;
    step(9);
    check("tm_before_1", 32'(raise_t), 32'd0);
    step(1);
    check("tm_tick_1", 32'(raise_t), 32'd1);
    step(1); ack_t = 2'b01;
    step(1); ack_t = 2'b00;
    check("tm_ack_1", 32'(raise_t), 32'd0);
    step(7);
    check("tm_before_2", 32'(raise_t), 32'd0);
    step(1);
    check("tm_tick_2", 32'(raise_t), 32'd1);
    step(1); ack_t = 2'b01;
    step(1); ack_t = 2'b00;
    check("tm_ack_2", 32'(raise_t), 32'd0);
    step(7); ev_t = 2'b01;
    step(1); ev_t = 2'b00;
    check("tm_tick_3_ev", 32'(raise_t), 32'd1);
    step(1); ack_t = 2'b01;
    step(1); ack_t = 2'b00;
    check("tm_ack_3", 32'(raise_t), 32'd0);
    step(1);
    check("tm_single_event", 32'(raise_t), 32'd0);
    step(6);
    check("tm_before_4", 32'(raise_t), 32'd0);
    step(1);
    check("tm_tick_4", 32'(raise_t), 32'd1);
    check("tm_ovf0", 32'(ovf0_t), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
